// File: rtl/prefetch_wd_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Package  : prefetch_wd_pkg
// Function : shared types for the AR outstanding watchdog (error codes, slot)
// Revision : 1.0
//------------------------------------------------------------------------------
package prefetch_wd_pkg;

    localparam int ERR_CODE_W = 3;

    // Slot field widths; the watchdog parameters default to these values.
    localparam int SLOT_ID_W  = 8;
    localparam int SLOT_LEN_W = 8;
    localparam int SLOT_AGE_W = 3;
    localparam int SLOT_CNT_W = 10;

    typedef enum logic [ERR_CODE_W-1:0] {
        ERR_NONE     = 3'd0,
        ERR_TIMEOUT  = 3'd1,
        ERR_UNEXP_R  = 3'd2,
        ERR_LEN      = 3'd3,
        ERR_OVERFLOW = 3'd4
    } err_code_e;

    typedef struct packed {
        logic                  valid;
        logic [SLOT_ID_W-1:0]  id;
        logic [SLOT_LEN_W-1:0] len;
        logic [SLOT_LEN_W-1:0] beats;
        logic [SLOT_AGE_W-1:0] age;
        logic [SLOT_CNT_W-1:0] cnt;
    } slot_t;

endpackage
`default_nettype wire

// File: rtl/wd_ffs_alloc.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : wd_ffs_alloc
// Function : lowest-set-bit priority encoder (onehot, index, none flag)
// Revision : 1.0
//------------------------------------------------------------------------------
module wd_ffs_alloc #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             none
);

    // Scan downwards so the lowest requesting bit is the last one written.
    always_comb begin
        onehot = '0;
        idx    = '0;
        none   = 1'b1;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
                none      = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ar_outstanding_watchdog.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : ar_outstanding_watchdog
// Function : passive per-slot AR/R burst watchdog with sticky error code;
//            AR_OUTSTANDING_WATCHDOG_STATS_EN adds latency/timeout statistics
// Revision : 1.0
//------------------------------------------------------------------------------
module ar_outstanding_watchdog
    import prefetch_wd_pkg::*;
#(
    parameter int ID_WIDTH        = SLOT_ID_W,
    parameter int BURST_LEN_WIDTH = SLOT_LEN_W,
    parameter int LOG_DEPTH       = SLOT_AGE_W,
    parameter int WATCHDOG_SIZE   = SLOT_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       ar_valid,
    input  logic                       ar_ready,
    input  logic [ID_WIDTH-1:0]        ar_id,
    input  logic [BURST_LEN_WIDTH-1:0] ar_len,
    input  logic                       r_valid,
    input  logic                       r_ready,
    input  logic [ID_WIDTH-1:0]        r_id,
    input  logic                       r_last,
    input  logic [WATCHDOG_SIZE-1:0]   cfg_timeout,
    input  logic                       err_clear,
    output logic                       full,
    output logic [LOG_DEPTH:0]         outstanding,
    output logic [ERR_CODE_W-1:0]      err_code,
    output logic [ID_WIDTH-1:0]        err_id
`ifdef AR_OUTSTANDING_WATCHDOG_STATS_EN
    ,
    output logic [WATCHDOG_SIZE-1:0]   stat_max_lat,
    output logic [15:0]                stat_timeouts
`endif
);

    localparam int c_depth = 1 << LOG_DEPTH;

    slot_t                      r_slot     [c_depth];
    slot_t                      w_slot_nxt [c_depth];
    err_code_e                  r_err_code;
    logic [ID_WIDTH-1:0]        r_err_id;
    logic                       r_full;
    logic [LOG_DEPTH:0]         r_outstanding;

    logic                       w_ar_fire;
    logic                       w_r_fire;
    logic                       w_alloc;
    logic                       w_free;
    logic [c_depth-1:0]         w_valid;
    logic [c_depth-1:0]         w_free_oh;
    logic [c_depth-1:0]         w_alloc_oh;
    logic [c_depth-1:0]         w_valid_nxt;
    logic [LOG_DEPTH-1:0]       w_alloc_idx;
    logic                       w_alloc_none;
    logic                       w_hit;
    logic [LOG_DEPTH-1:0]       w_hit_idx;
    logic [BURST_LEN_WIDTH-1:0] w_hit_beats;
    logic [BURST_LEN_WIDTH-1:0] w_hit_len;
    logic                       w_to_hit;
    logic [ID_WIDTH-1:0]        w_to_id;
    logic [LOG_DEPTH-1:0]       w_new_age;
    logic                       w_err_ovf;
    logic                       w_err_unexp;
    logic                       w_err_len;

    assign w_ar_fire = ar_valid & ar_ready & en;
    assign w_r_fire  = r_valid & r_ready & en;

    always_comb begin
        w_valid = '0;
        for (int i = 0; i < c_depth; i++) begin
            w_valid[i] = r_slot[i].valid;
        end
    end

    wd_ffs_alloc #(
        .WIDTH (c_depth),
        .IDX_W (LOG_DEPTH)
    ) u_alloc (
        .req    (~w_valid),
        .onehot (w_alloc_oh),
        .idx    (w_alloc_idx),
        .none   (w_alloc_none)
    );

    // Heads (age 0) are the only slots that time out or accept R beats.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_to_hit  = 1'b0;
        w_to_id   = '0;
        for (int i = c_depth - 1; i >= 0; i--) begin
            if (r_slot[i].valid && r_slot[i].age == '0) begin
                if (r_slot[i].id == r_id) begin
                    w_hit     = 1'b1;
                    w_hit_idx = LOG_DEPTH'(i);
                end
                if (en && cfg_timeout != '0 && r_slot[i].cnt == cfg_timeout) begin
                    w_to_hit = 1'b1;
                    w_to_id  = r_slot[i].id;
                end
            end
        end
    end

    assign w_hit_beats = r_slot[w_hit_idx].beats;
    assign w_hit_len   = r_slot[w_hit_idx].len;
    assign w_free      = w_r_fire & w_hit & r_last;
    assign w_alloc     = w_ar_fire & ~w_alloc_none;

    assign w_err_ovf   = w_ar_fire & w_alloc_none;
    assign w_err_unexp = w_r_fire & ~w_hit;
    assign w_err_len   = w_r_fire & w_hit &
                         (r_last ? (w_hit_beats != w_hit_len) : (w_hit_beats == w_hit_len));

    // A slot freed this cycle no longer counts towards the new burst's age.
    always_comb begin
        w_free_oh = '0;
        w_new_age = '0;
        for (int i = 0; i < c_depth; i++) begin
            if (w_free && LOG_DEPTH'(i) == w_hit_idx) begin
                w_free_oh[i] = 1'b1;
            end else if (r_slot[i].valid && r_slot[i].id == ar_id) begin
                w_new_age = w_new_age + LOG_DEPTH'(1);
            end
        end
    end

    assign w_valid_nxt = (w_valid & ~w_free_oh) | (w_alloc ? w_alloc_oh : '0);

    always_comb begin
        for (int i = 0; i < c_depth; i++) begin
            w_slot_nxt[i] = r_slot[i];
            if (en && r_slot[i].valid && r_slot[i].age == '0 && r_slot[i].cnt != '1) begin
                w_slot_nxt[i].cnt = r_slot[i].cnt + WATCHDOG_SIZE'(1);
            end
            if (w_r_fire && w_hit && LOG_DEPTH'(i) == w_hit_idx) begin
                w_slot_nxt[i].beats = r_slot[i].beats + BURST_LEN_WIDTH'(1);
                w_slot_nxt[i].cnt   = '0;
                w_slot_nxt[i].valid = ~r_last;
            end else if (w_free && r_slot[i].valid && r_slot[i].id == r_id) begin
                w_slot_nxt[i].age = r_slot[i].age - LOG_DEPTH'(1);
            end
            if (w_alloc && LOG_DEPTH'(i) == w_alloc_idx) begin
                w_slot_nxt[i].valid = 1'b1;
                w_slot_nxt[i].id    = ar_id;
                w_slot_nxt[i].len   = ar_len;
                w_slot_nxt[i].beats = '0;
                w_slot_nxt[i].age   = w_new_age;
                w_slot_nxt[i].cnt   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_depth; i++) begin
                r_slot[i] <= '0;
            end
            r_full        <= 1'b0;
            r_outstanding <= '0;
        end else begin
            for (int i = 0; i < c_depth; i++) begin
                r_slot[i] <= w_slot_nxt[i];
            end
            r_full        <= &w_valid_nxt;
            r_outstanding <= (LOG_DEPTH+1)'($countones(w_valid_nxt));
        end
    end

    // First error sticks; same-cycle priority overflow > unexpected R > length > timeout.
    always_ff @(posedge clk) begin
        if (rst || err_clear) begin
            r_err_code <= ERR_NONE;
            r_err_id   <= '0;
        end else if (r_err_code == ERR_NONE) begin
            if (w_err_ovf) begin
                r_err_code <= ERR_OVERFLOW;
                r_err_id   <= ar_id;
            end else if (w_err_unexp) begin
                r_err_code <= ERR_UNEXP_R;
                r_err_id   <= r_id;
            end else if (w_err_len) begin
                r_err_code <= ERR_LEN;
                r_err_id   <= r_id;
            end else if (w_to_hit) begin
                r_err_code <= ERR_TIMEOUT;
                r_err_id   <= w_to_id;
            end
        end
    end

    assign full        = r_full;
    assign outstanding = r_outstanding;
    assign err_code    = r_err_code;
    assign err_id      = r_err_id;

`ifdef AR_OUTSTANDING_WATCHDOG_STATS_EN
    logic [WATCHDOG_SIZE-1:0] r_stat_max_lat;
    logic [15:0]              r_stat_timeouts;
    logic [WATCHDOG_SIZE-1:0] w_hit_cnt;

    assign w_hit_cnt = r_slot[w_hit_idx].cnt;

    always_ff @(posedge clk) begin
        if (rst || err_clear) begin
            r_stat_max_lat  <= '0;
            r_stat_timeouts <= '0;
        end else begin
            if (w_r_fire && w_hit && w_hit_cnt > r_stat_max_lat) begin
                r_stat_max_lat <= w_hit_cnt;
            end
            if (w_to_hit && r_stat_timeouts != 16'hFFFF) begin
                r_stat_timeouts <= r_stat_timeouts + 16'd1;
            end
        end
    end

    assign stat_max_lat  = r_stat_max_lat;
    assign stat_timeouts = r_stat_timeouts;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ar_outstanding_watchdog.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_ar_outstanding_watchdog
// Function : scoreboard bench for ar_outstanding_watchdog against a burst-list model
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_ar_outstanding_watchdog;

    localparam int c_depth   = 8;
    localparam int c_cnt_max = 1023;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        ar_valid;
    logic        ar_ready;
    logic [7:0]  ar_id;
    logic [7:0]  ar_len;
    logic        r_valid;
    logic        r_ready;
    logic [7:0]  r_id;
    logic        r_last;
    logic [9:0]  cfg_timeout;
    logic        err_clear;
    logic        full;
    logic [3:0]  outstanding;
    logic [2:0]  err_code;
    logic [7:0]  err_id;
`ifdef AR_OUTSTANDING_WATCHDOG_STATS_EN
    logic [9:0]  stat_max_lat;
    logic [15:0] stat_timeouts;
`endif

    always #5 clk = ~clk;

    ar_outstanding_watchdog u_dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .ar_valid    (ar_valid),
        .ar_ready    (ar_ready),
        .ar_id       (ar_id),
        .ar_len      (ar_len),
        .r_valid     (r_valid),
        .r_ready     (r_ready),
        .r_id        (r_id),
        .r_last      (r_last),
        .cfg_timeout (cfg_timeout),
        .err_clear   (err_clear),
        .full        (full),
        .outstanding (outstanding),
        .err_code    (err_code),
        .err_id      (err_id)
`ifdef AR_OUTSTANDING_WATCHDOG_STATS_EN
        ,
        .stat_max_lat  (stat_max_lat),
        .stat_timeouts (stat_timeouts)
`endif
    );

    // Outstanding bursts in issue order; the oldest entry of an id is its head.
    typedef struct {
        int id;
        int len;
        int beats;
        int cnt;
        int slot;
    } burst_t;

    typedef struct {
        int cyc;
        int full;
        int outs;
        int code;
        int id;
        int max_lat;
        int tos;
    } exp_t;

    burst_t m_q[$];
    exp_t   sb[$];
    int     m_code, m_id, m_max, m_to;
    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;

    function automatic bit is_head(int k);
        for (int j = 0; j < k; j++) begin
            if (m_q[j].id == m_q[k].id) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step();
        bit     arf, rf, ovf, unexp, lenerr, to;
        int     head, to_id, to_slot, free_slot;
        bit     used [c_depth];
        burst_t nb;
        exp_t   e;
        if (rst) begin
            m_q.delete();
            m_code = 0; m_id = 0; m_max = 0; m_to = 0;
        end else begin
            arf  = ar_valid && ar_ready && en;
            rf   = r_valid && r_ready && en;
            head = -1;
            for (int k = 0; k < m_q.size(); k++) begin
                if (m_q[k].id == int'(r_id)) begin head = k; break; end
            end
            ovf    = arf && (m_q.size() == c_depth);
            unexp  = rf && (head < 0);
            lenerr = rf && (head >= 0) &&
                     (r_last ? (m_q[head].beats != m_q[head].len) : (m_q[head].beats == m_q[head].len));
            to = 1'b0; to_id = 0; to_slot = c_depth;
            if (en && cfg_timeout != 0) begin
                for (int k = 0; k < m_q.size(); k++) begin
                    if (is_head(k) && m_q[k].cnt == int'(cfg_timeout) && m_q[k].slot < to_slot) begin
                        to = 1'b1; to_id = m_q[k].id; to_slot = m_q[k].slot;
                    end
                end
            end
            foreach (used[s]) used[s] = 1'b0;
            foreach (m_q[k]) used[m_q[k].slot] = 1'b1;
            free_slot = 0;
            for (int s = c_depth - 1; s >= 0; s--) if (!used[s]) free_slot = s;

            if (rf && head >= 0 && m_q[head].cnt > m_max) m_max = m_q[head].cnt;
            if (to && m_to < 65535) m_to++;

            if (en) begin
                for (int k = 0; k < m_q.size(); k++) begin
                    if (is_head(k) && m_q[k].cnt < c_cnt_max) m_q[k].cnt++;
                end
            end
            if (rf && head >= 0) begin
                m_q[head].beats++;
                m_q[head].cnt = 0;
                if (r_last) m_q.delete(head);
            end
            if (arf && !ovf) begin
                nb.id = int'(ar_id); nb.len = int'(ar_len); nb.beats = 0; nb.cnt = 0; nb.slot = free_slot;
                m_q.push_back(nb);
            end

            if (err_clear) begin
                m_code = 0; m_id = 0; m_max = 0; m_to = 0;
            end else if (m_code == 0) begin
                if (ovf)         begin m_code = 4; m_id = int'(ar_id); end
                else if (unexp)  begin m_code = 2; m_id = int'(r_id);  end
                else if (lenerr) begin m_code = 3; m_id = int'(r_id);  end
                else if (to)     begin m_code = 1; m_id = to_id;       end
            end
        end
        e.cyc = cyc; e.full = (m_q.size() == c_depth) ? 1 : 0; e.outs = m_q.size();
        e.code = m_code; e.id = m_id; e.max_lat = m_max; e.tos = m_to;
        sb.push_back(e);
    endtask

    task automatic chk(string name, int c, logic [31:0] got, logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, c, got, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("full",        e.cyc, 32'(full),        32'(e.full));
            chk("outstanding", e.cyc, 32'(outstanding), 32'(e.outs));
            chk("err_code",    e.cyc, 32'(err_code),    32'(e.code));
            chk("err_id",      e.cyc, 32'(err_id),      32'(e.id));
`ifdef AR_OUTSTANDING_WATCHDOG_STATS_EN
            chk("stat_max_lat",  e.cyc, 32'(stat_max_lat),  32'(e.max_lat));
            chk("stat_timeouts", e.cyc, 32'(stat_timeouts), 32'(e.tos));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic drive(bit arv, int aid, int alen, bit rv, int rid, bit rl, bit clr);
        ar_valid  = arv;  ar_id = 8'(aid); ar_len = 8'(alen);
        r_valid   = rv;   r_id  = 8'(rid); r_last = rl;
        err_clear = clr;
        step();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        rst = 1'b1; en = 1'b1; ar_ready = 1'b1; r_ready = 1'b1; cfg_timeout = '0;
        ar_valid = 0; ar_id = 0; ar_len = 0; r_valid = 0; r_id = 0; r_last = 0; err_clear = 0;
        idle(3);
        rst = 1'b0;

        // Single burst, four beats.
        drive(1, 5, 3, 0, 0, 0, 0);
        for (int b = 0; b < 4; b++) drive(0, 0, 0, 1, 5, (b == 3), 0);
        idle(2);

        // Timeout on a burst with no data.
        cfg_timeout = 10'd10;
        drive(1, 5, 0, 0, 0, 0, 0);
        idle(13);
        drive(0, 0, 0, 1, 5, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        cfg_timeout = '0;

        // Same id twice: in-order completion.
        drive(1, 2, 0, 0, 0, 0, 0);
        drive(1, 2, 0, 0, 0, 0, 0);
        idle(3);
        drive(0, 0, 0, 1, 2, 1, 0);
        idle(2);
        drive(0, 0, 0, 1, 2, 1, 0);
        idle(1);

        // Fill, overflow, clear, drain.
        for (int i = 0; i < 8; i++) drive(1, i, 0, 0, 0, 0, 0);
        drive(1, 8, 0, 0, 0, 0, 0);
        idle(1);
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, i, 1, 0);

        // Unexpected R, then length mismatch.
        drive(0, 0, 0, 1, 9, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(1, 4, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 4, 1, 0);
        idle(1);
        drive(0, 0, 0, 0, 0, 0, 1);

        // Latency statistic: beats at different ages.
        drive(1, 1, 1, 0, 0, 0, 0);
        idle(2);
        drive(0, 0, 0, 1, 1, 0, 0);
        idle(6);
        drive(0, 0, 0, 1, 1, 1, 0);
        idle(2);

        // Randomized traffic with a mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            bit arv, rv, rl, clr;
            int aid, alen, rid, k, h;
            if (c == 1500) begin
                rst = 1'b1; idle(2); rst = 1'b0;
            end
            if ($urandom_range(99) == 0) begin
                case ($urandom_range(3))
                    0: cfg_timeout = 10'd0;
                    1: cfg_timeout = 10'd5;
                    2: cfg_timeout = 10'd12;
                    default: cfg_timeout = 10'd30;
                endcase
            end
            en       = ($urandom_range(9) != 0);
            ar_ready = ($urandom_range(3) != 0);
            r_ready  = ($urandom_range(4) != 0);
            arv  = ($urandom_range(9) < 4);
            aid  = ($urandom_range(15) == 0) ? int'($urandom_range(255)) : int'($urandom_range(3));
            alen = $urandom_range(3);
            rv   = ($urandom_range(9) < 5);
            if (m_q.size() > 0 && $urandom_range(9) != 0) begin
                k   = $urandom_range(m_q.size() - 1);
                rid = m_q[k].id;
                h   = k;
                for (int j = k - 1; j >= 0; j--) if (m_q[j].id == rid) h = j;
                rl  = (m_q[h].beats == m_q[h].len);
                if ($urandom_range(19) == 0) rl = !rl;
            end else begin
                rid = 9;
                rl  = $urandom_range(1);
            end
            clr = ($urandom_range(19) == 0);
            drive(arv, aid, alen, rv, rid, rl, clr);
        end

        idle(2);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
